// File: rtl/alu_sequencer.sv
// Issue-side controller for the KGP-RISC ALU: takes one decoded instruction at a time,
// drives the ALU operands/control (two passes for diff) and returns the result plus carry.
module alu_sequencer #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] rs_val,
   input  logic [DATA_W-1:0] rt_val,
   input  logic [15:0]       imm,
   input  logic [4:0]        shamt,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [4:0]        alu_shamt,
   output logic [3:0]        alu_control,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_flag,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] result,
   output logic              illegal,
   output logic              carry,
   output logic [1:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC1 = 2'd1, S_EXEC2 = 2'd2, S_RESP = 2'd3} state_t;

   localparam logic [3:0] OP_ADD = 4'd0,  OP_COMP  = 4'd1,  OP_AND   = 4'd2,  OP_XOR   = 4'd3;
   localparam logic [3:0] OP_SHLL = 4'd4, OP_SHRL  = 4'd5,  OP_SHRA  = 4'd6,  OP_SHLLV = 4'd7;
   localparam logic [3:0] OP_SHRLV = 4'd8, OP_SHRAV = 4'd9, OP_DIFF  = 4'd10, OP_ADDI  = 4'd11;
   localparam logic [3:0] OP_COMPI = 4'd12;

   state_t              r_state, w_next;
   logic [3:0]          r_op;
   logic [DATA_W-1:0]   r_rs, r_rt, r_tmp, r_result;
   logic [15:0]         r_imm;
   logic [4:0]          r_shamt;
   logic                r_illegal, r_carry;
   logic                w_accept, w_in_legal;
   logic [DATA_W-1:0]   w_sext;

   assign w_accept   = (r_state == S_IDLE) && in_valid;
   assign w_in_legal = (op <= OP_COMPI);
   assign w_sext     = {{(DATA_W-16){r_imm[15]}}, r_imm};
   assign result     = r_result;
   assign illegal    = r_illegal;
   assign carry      = r_carry;
   assign dbg_state  = r_state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_next = w_in_legal ? S_EXEC1 : S_RESP;
         S_EXEC1: w_next = (r_op == OP_DIFF) ? S_EXEC2 : S_RESP;
         S_EXEC2: w_next = S_RESP;
         S_RESP:  if (res_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready    = (r_state == S_IDLE);
      res_valid   = (r_state == S_RESP);
      alu_in1     = '0;
      alu_in2     = '0;
      alu_shamt   = '0;
      alu_control = 4'b0000;
      if (r_state == S_EXEC1) begin
         case (r_op)
            OP_ADD:   begin alu_in1 = r_rs; alu_in2 = r_rt;   alu_control = 4'b0000; end
            OP_COMP:  begin                 alu_in2 = r_rt;   alu_control = 4'b0001; end
            OP_AND:   begin alu_in1 = r_rs; alu_in2 = r_rt;   alu_control = 4'b0010; end
            OP_XOR:   begin alu_in1 = r_rs; alu_in2 = r_rt;   alu_control = 4'b0011; end
            OP_SHLL:  begin alu_in1 = r_rs; alu_shamt = r_shamt; alu_control = 4'b0100; end
            OP_SHRL:  begin alu_in1 = r_rs; alu_shamt = r_shamt; alu_control = 4'b0101; end
            OP_SHRA:  begin alu_in1 = r_rs; alu_shamt = r_shamt; alu_control = 4'b0110; end
            OP_SHLLV: begin alu_in1 = r_rs; alu_in2 = r_rt;   alu_control = 4'b1100; end
            OP_SHRLV: begin alu_in1 = r_rs; alu_in2 = r_rt;   alu_control = 4'b1101; end
            OP_SHRAV: begin alu_in1 = r_rs; alu_in2 = r_rt;   alu_control = 4'b1110; end
            OP_DIFF:  begin                 alu_in2 = r_rt;   alu_control = 4'b0001; end
            OP_ADDI:  begin alu_in1 = r_rs; alu_in2 = w_sext; alu_control = 4'b0000; end
            OP_COMPI: begin                 alu_in2 = w_sext; alu_control = 4'b0001; end
            default:  alu_control = 4'b0000;
         endcase
      end else if (r_state == S_EXEC2) begin
         // Second diff pass: rs plus the negated rt captured in pass one.
         alu_in1 = r_rs;
         alu_in2 = r_tmp;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op      <= '0;
         r_rs      <= '0;
         r_rt      <= '0;
         r_imm     <= '0;
         r_shamt   <= '0;
         r_tmp     <= '0;
         r_result  <= '0;
         r_illegal <= 1'b0;
         r_carry   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op      <= op;
            r_rs      <= rs_val;
            r_rt      <= rt_val;
            r_imm     <= imm;
            r_shamt   <= shamt;
            r_illegal <= !w_in_legal;
            if (!w_in_legal) r_result <= '0;
         end
         if (r_state == S_EXEC1) begin
            r_tmp <= alu_out;
            if (r_op != OP_DIFF) r_result <= alu_out;
            if (r_op == OP_ADD || r_op == OP_ADDI) r_carry <= alu_flag;
         end
         if (r_state == S_EXEC2) begin
            r_result <= alu_out;
            r_carry  <= alu_flag;
         end
      end
   end

endmodule
